// File: rtl/pool_channel_scheduler.sv
// pool_channel_scheduler
// Round-robin arbiter that lends one pooling engine to NUM_CH convolution
// output channels. A granted channel owns the engine for one session: the
// scheduler pulses pool_start, turns every pool_done into an output-buffer
// write inside that channel's region, and on pool_finish checks the output
// count and pulses that channel's ch_done bit.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no session; arbitrate among req, starting the search at rr_ptr
// START | one-cycle pool_start to the engine
// RUN   | engine active; pool_done -> buffer write, pool_finish -> DONE
// DONE  | one-cycle ch_done pulse; advance rr_ptr past the served channel
//
// Ports:
//   clk, nrst    clock, asynchronous active-low reset
//   req          per-channel request level (sampled only in IDLE)
//   grant        one-hot grant, held through START and RUN
//   sel_ch       index of the granted channel (datapath mux select)
//   pool_start   one-cycle engine start
//   pool_done    engine output-valid strobe
//   pool_finish  engine end-of-map strobe
//   wr_en        output buffer write enable (combinational from pool_done)
//   wr_addr      output buffer write address = region base + output count
//   ch_done      one-cycle completion pulse, bit = finished channel
//   busy         high whenever the FSM is not in IDLE
//   cnt_err      sticky count/stray-strobe error, cleared only by reset
module pool_channel_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int OUT_W    = 14,
  parameter int OUT_ROWS = 14,
  parameter int ADDR_W   = 10,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   sel_ch,
  output logic              pool_start,
  input  logic              pool_done,
  input  logic              pool_finish,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [NUM_CH-1:0] ch_done,
  output logic              busy,
  output logic              cnt_err
);

  localparam int EXP   = OUT_W * OUT_ROWS;
  localparam int CNT_W = $clog2(EXP + 1);
  localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [NUM_CH-1:0]   grant_q;
  logic [CH_W-1:0]     sel_q;
  logic [ADDR_W-1:0]   base_q;
  logic [CH_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]    out_cnt;
  logic                cnt_err_q;

  logic                win_vld;
  logic [CH_W-1:0]     win_idx;
  logic [CH_W-1:0]     cand;
  logic                err_set;
  logic [CNT_W-1:0]    fin_cnt;

  // First requester at or above rr_ptr, wrapping; the channel just served
  // sits at the far end of the search and so has lowest priority.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    pool_start = 1'b0;
    wr_en      = 1'b0;
    ch_done    = '0;
    err_set    = 1'b0;
    fin_cnt    = out_cnt;
    case (state)
      IDLE: begin
        if (win_vld) state_nxt = START;
        if (pool_done || pool_finish) err_set = 1'b1;
      end
      START: begin
        pool_start = 1'b1;
        state_nxt  = RUN;
        if (pool_done || pool_finish) err_set = 1'b1;
      end
      RUN: begin
        // A full region refuses further writes so the next channel's
        // region is never touched.
        if (pool_done) begin
          if (out_cnt < EXP_C) wr_en = 1'b1;
          else                 err_set = 1'b1;
        end
        // The final output usually arrives together with pool_finish.
        fin_cnt = out_cnt + CNT_W'(wr_en);
        if (pool_finish) begin
          state_nxt = DONE;
          if (fin_cnt != EXP_C) err_set = 1'b1;
        end
      end
      DONE: begin
        ch_done   = NUM_CH'(1) << sel_q;
        state_nxt = IDLE;
        if (pool_done || pool_finish) err_set = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      base_q    <= '0;
      rr_ptr    <= '0;
      out_cnt   <= '0;
      cnt_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (err_set) cnt_err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant_q <= NUM_CH'(1) << win_idx;
            sel_q   <= win_idx;
            base_q  <= ADDR_W'(int'(win_idx) * EXP);
            out_cnt <= '0;
          end
        end
        RUN: begin
          if (wr_en)       out_cnt <= out_cnt + CNT_W'(1);
          if (pool_finish) grant_q <= '0;
        end
        DONE: rr_ptr <= (sel_q == LAST_CH) ? '0 : sel_q + CH_W'(1);
        default: ;
      endcase
    end
  end

  assign grant   = grant_q;
  assign sel_ch  = sel_q;
  assign wr_addr = base_q + ADDR_W'(out_cnt);
  assign busy    = (state != IDLE);
  assign cnt_err = cnt_err_q;

endmodule

// File: tb/tb_pool_channel_scheduler.sv
module tb_pool_channel_scheduler;

  localparam int NUM_CH = 4;
  localparam int EXP    = 196;

  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [1:0]  sel_ch;
  logic        pool_start;
  logic        pool_done;
  logic        pool_finish;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [3:0]  ch_done;
  logic        busy;
  logic        cnt_err;

  pool_channel_scheduler dut (
    .clk(clk), .nrst(nrst), .req(req), .grant(grant), .sel_ch(sel_ch),
    .pool_start(pool_start), .pool_done(pool_done), .pool_finish(pool_finish),
    .wr_en(wr_en), .wr_addr(wr_addr), .ch_done(ch_done), .busy(busy),
    .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int cur_ch, cur_base, cur_cnt;
  logic err_model;

  function automatic logic [3:0] oh(input int c);
    return 4'b0001 << c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_sel_ch"}, 32'(sel_ch), 32'd0);
    chk({tag, "_pool_start"}, 32'(pool_start), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_ch_done"}, 32'(ch_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cnt_err"}, 32'(cnt_err), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; req = '0; pool_done = 1'b0; pool_finish = 1'b0;
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    nrst = 1'b1;
    err_model = 1'b0;
    exp_q.delete();
  endtask

  // One engine cycle in RUN; the expected address is queued before the DUT
  // is sampled and popped when it asserts wr_en.
  task automatic step(input logic pd, input logic pf);
    logic we;
    @(negedge clk);
    pool_done = pd; pool_finish = pf;
    we = pd && (cur_cnt < EXP);
    if (we) begin
      exp_q.push_back(cur_base + cur_cnt);
      cur_cnt++;
    end
    #1;
    chk("wr_en", 32'(wr_en), 32'(we));
    chk("grant_hold", 32'(grant), 32'(oh(cur_ch)));
    if (wr_en === 1'b1) begin
      if (exp_q.size() > 0) chk("wr_addr", 32'(wr_addr), 32'(exp_q.pop_front()));
      else                  chk("wr_addr_unexpected", 32'(wr_addr), 32'hFFFF);
    end
  endtask

  task automatic begin_session(input logic [3:0] reqv, input int ch, input bit b2b);
    if (!b2b) begin
      @(negedge clk);
      req = reqv;
      #1;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_pool_start", 32'(pool_start), 32'd0);
    end
    @(negedge clk);
    #1;
    chk("start_pulse", 32'(pool_start), 32'd1);
    chk("start_grant", 32'(grant), 32'(oh(ch)));
    chk("start_sel_ch", 32'(sel_ch), 32'(ch));
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_cnt_err", 32'(cnt_err), 32'(err_model));
    cur_ch = ch; cur_base = ch * EXP; cur_cnt = 0;
  endtask

  task automatic run_engine(input int n, input bit fin_last);
    for (int i = 0; i < n; i++) step(1'b1, fin_last && (i == n - 1));
  endtask

  task automatic end_session(input int ch, input bit hold);
    @(negedge clk);
    pool_done = 1'b0; pool_finish = 1'b0;
    if (!hold) req = '0;
    #1;
    chk("done_ch_done", 32'(ch_done), 32'(oh(ch)));
    chk("done_grant", 32'(grant), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_cnt_err", 32'(cnt_err), 32'(err_model));
    @(negedge clk);
    #1;
    chk("after_ch_done", 32'(ch_done), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    chk("after_pool_start", 32'(pool_start), 32'd0);
  endtask

  initial begin
    nrst = 1'b0; req = '0; pool_done = 1'b0; pool_finish = 1'b0;
    err_model = 1'b0;
    do_reset();

    // single channel: ch2, addresses 392..587
    begin_session(4'b0100, 2, 1'b0);
    run_engine(EXP, 1'b1);
    end_session(2, 1'b0);

    // fairness: after ch2, 0101 -> ch0 (wraps from ptr 3), then ch2
    begin_session(4'b0101, 0, 1'b0);
    run_engine(EXP, 1'b1);
    end_session(0, 1'b1);
    begin_session(4'b0101, 2, 1'b1);
    run_engine(EXP, 1'b1);
    end_session(2, 1'b0);

    // round robin with all requesting, back-to-back sessions from ptr 3
    begin_session(4'b1111, 3, 1'b0);
    run_engine(EXP, 1'b1);
    end_session(3, 1'b1);
    for (int c = 0; c < NUM_CH; c++) begin
      begin_session(4'b1111, (c + 0) % NUM_CH, 1'b1);
      run_engine(EXP, 1'b1);
      end_session(c, c != NUM_CH - 1);
    end
    // that last loop pass served ch3 again, so ptr is back at 0

    // short map: 195 outputs -> error at finish, next channel still served
    begin_session(4'b0010, 1, 1'b0);
    run_engine(EXP - 1, 1'b1);
    err_model = 1'b1;
    end_session(1, 1'b0);
    begin_session(4'b1000, 3, 1'b0);
    run_engine(EXP, 1'b1);
    end_session(3, 1'b0);

    // overflow: 197th pool_done is refused and flags an error
    do_reset();
    begin_session(4'b0001, 0, 1'b0);
    run_engine(EXP, 1'b0);
    chk("pre_overflow_cnt_err", 32'(cnt_err), 32'd0);
    step(1'b1, 1'b1);
    err_model = 1'b1;
    end_session(0, 1'b0);

    // stray pool_done in IDLE
    do_reset();
    @(negedge clk);
    pool_done = 1'b1;
    #1;
    chk("stray_wr_en", 32'(wr_en), 32'd0);
    chk("stray_cnt_err_before", 32'(cnt_err), 32'd0);
    @(negedge clk);
    pool_done = 1'b0;
    #1;
    chk("stray_cnt_err", 32'(cnt_err), 32'd1);
    chk("stray_busy", 32'(busy), 32'd0);

    // async reset mid-RUN after 50 writes, checked before any clock edge
    do_reset();
    begin_session(4'b0010, 1, 1'b0);
    run_engine(50, 1'b0);
    #2;
    nrst = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(negedge clk);
    pool_done = 1'b0; req = '0;
    nrst = 1'b1;
    err_model = 1'b0;
    begin_session(4'b0010, 1, 1'b0);
    run_engine(EXP, 1'b1);
    end_session(1, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
